// File: rtl/tsn_tx_gate_scheduler.sv
// rtl/tsn_tx_gate_scheduler.sv - time-aware strict-priority TX scheduler with gate control list
module tsn_tx_gate_scheduler #(
  parameter int DEPTH = 16,
  parameter int IFG   = 12,
  parameter int LEN_W = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [7:0]               q_valid,
  input  logic [8*LEN_W-1:0]       q_len,
  input  logic [63:0]              q_data,
  input  logic [7:0]               q_last,
  output logic [7:0]               q_rd,
  input  logic                     gcl_en,
  input  logic [$clog2(DEPTH):0]   gcl_len,
  input  logic                     gcl_wr_en,
  input  logic [$clog2(DEPTH)-1:0] gcl_wr_addr,
  input  logic [7:0]               gcl_wr_gate,
  input  logic [LEN_W-1:0]         gcl_wr_interval,
  output logic                     m_mac_tx_en,
  output logic [7:0]               m_mac_tx_d,
  output logic [7:0]               m_gate_state
);

  localparam int AW   = $clog2(DEPTH);
  localparam int GW   = AW + 1;
  localparam int GAPW = $clog2(IFG + 1);

  typedef enum logic [1:0] {S_IDLE, S_TX, S_GAP} state_t;

  logic [7:0]       gate_mem [DEPTH];
  logic [LEN_W-1:0] intv_mem [DEPTH];

  logic [AW-1:0]    ptr;
  logic [LEN_W-1:0] cnt;
  logic             run;
  logic [LEN_W-1:0] cur_int;
  logic [LEN_W-1:0] remaining;
  logic [7:0]       eff_gate;
  logic [7:0]       elig;
  logic [2:0]       hi;

  state_t           state, state_d;
  logic [2:0]       sel, sel_d;
  logic [GAPW-1:0]  gap_cnt, gap_d;
  logic [7:0]       rd_vec;
  logic [2:0]       rd_idx;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        gate_mem[i] <= 8'hFF;
        intv_mem[i] <= LEN_W'(1);
      end
    end else if (gcl_wr_en) begin
      gate_mem[gcl_wr_addr] <= gcl_wr_gate;
      intv_mem[gcl_wr_addr] <= gcl_wr_interval;
    end
  end

  assign run       = gcl_en && (gcl_len != '0);
  assign cur_int   = (intv_mem[ptr] == '0) ? LEN_W'(1) : intv_mem[ptr];
  assign remaining = cur_int - cnt;
  assign eff_gate  = run ? gate_mem[ptr] : 8'hFF;

  // ptr/cnt sit at 0 whenever the cycle is stopped, so a rising gcl_en restarts at entry 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= '0;
      cnt <= '0;
    end else if (!run) begin
      ptr <= '0;
      cnt <= '0;
    end else if (cnt == cur_int - LEN_W'(1)) begin
      cnt <= '0;
      ptr <= ({1'b0, ptr} >= gcl_len - GW'(1)) ? '0 : ptr + AW'(1);
    end else begin
      cnt <= cnt + LEN_W'(1);
    end
  end

  always_comb begin
    elig = '0;
    hi   = '0;
    for (int i = 0; i < 8; i++) begin
      elig[i] = q_valid[i] && eff_gate[i] &&
                (!run || (q_len[i*LEN_W +: LEN_W] <= remaining));
      if (elig[i]) hi = 3'(i);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      sel     <= '0;
      gap_cnt <= '0;
    end else begin
      state   <= state_d;
      sel     <= sel_d;
      gap_cnt <= gap_d;
    end
  end

  always_comb begin
    state_d = state;
    sel_d   = sel;
    gap_d   = gap_cnt;
    rd_vec  = '0;
    rd_idx  = sel;
    case (state)
      S_IDLE: begin
        if (elig != '0) begin
          rd_vec[hi] = 1'b1;
          rd_idx     = hi;
          sel_d      = hi;
          gap_d      = '0;
          state_d    = q_last[hi] ? S_GAP : S_TX;
        end
      end
      S_TX: begin
        rd_vec[sel] = 1'b1;
        if (q_last[sel]) begin
          gap_d   = '0;
          state_d = S_GAP;
        end
      end
      S_GAP: begin
        if (gap_cnt == GAPW'(IFG - 1)) state_d = S_IDLE;
        else                           gap_d   = gap_cnt + GAPW'(1);
      end
      default: state_d = S_IDLE;
    endcase
  end

  // No pops may escape while reset is held, even though IDLE could see an eligible class.
  assign q_rd = rst_n ? rd_vec : 8'h00;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_mac_tx_en  <= 1'b0;
      m_mac_tx_d   <= 8'h00;
      m_gate_state <= 8'hFF;
    end else begin
      m_mac_tx_en  <= (rd_vec != '0);
      m_mac_tx_d   <= (rd_vec != '0) ? q_data[{rd_idx, 3'b000} +: 8] : 8'h00;
      m_gate_state <= eff_gate;
    end
  end

endmodule
